madgwick_seq: RTL

- Sequences the madgwick filter core: accepts raw IMU samples from the sensor-reader front end and buffers one pending sample.
- Drives the core's valid_in/ready_in and valid_out/ready_out handshakes and captures each normalised quaternion into stable output registers.
- Keeps update and overrun counters for the SoC register wrapper.
- Sits between the attitude_sensor SPI/reader logic and the madgwick core inside the attitude_sensor peripheral.

---
 rtl/madgwick_seq.sv | 252 +++++++++++++++++++++++++
 1 files changed

// File: rtl/madgwick_seq.sv
// Sequencer for the madgwick filter core: one-deep sample buffer, core handshakes, quaternion capture.
// Optional watchdog enabled by defining MADGWICK_SEQ_TIMEOUT_EN.
module madgwick_seq #(
  parameter int unsigned ACC_W          = 11,
  parameter int unsigned GYRO_W         = 14,
  parameter int unsigned Q_W            = 16,
  parameter int unsigned CNT_W          = 16,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic                     smp_valid,
  input  logic signed [ACC_W-1:0]  smp_a_x,
  input  logic signed [ACC_W-1:0]  smp_a_y,
  input  logic signed [ACC_W-1:0]  smp_a_z,
  input  logic signed [GYRO_W-1:0] smp_w_x,
  input  logic signed [GYRO_W-1:0] smp_w_y,
  input  logic signed [GYRO_W-1:0] smp_w_z,
  output logic                     f_valid_in,
  input  logic                     f_ready_in,
  output logic signed [ACC_W-1:0]  f_a_x,
  output logic signed [ACC_W-1:0]  f_a_y,
  output logic signed [ACC_W-1:0]  f_a_z,
  output logic signed [GYRO_W-1:0] f_w_x,
  output logic signed [GYRO_W-1:0] f_w_y,
  output logic signed [GYRO_W-1:0] f_w_z,
  input  logic                     f_valid_out,
  output logic                     f_ready_out,
  input  logic        [Q_W-1:0]    f_q_w,
  input  logic        [Q_W-1:0]    f_q_x,
  input  logic        [Q_W-1:0]    f_q_y,
  input  logic        [Q_W-1:0]    f_q_z,
  output logic        [Q_W-1:0]    q_w,
  output logic        [Q_W-1:0]    q_x,
  output logic        [Q_W-1:0]    q_y,
  output logic        [Q_W-1:0]    q_z,
  output logic                     q_update,
  output logic                     busy,
  output logic        [CNT_W-1:0]  update_cnt,
  output logic        [CNT_W-1:0]  overrun_cnt,
  input  logic                     cnt_clr,
  output logic                     timeout_err
);

  // Core quaternion format is Q2.(Q_W-2): 1.0 has bit Q_W-2 set.
  localparam logic [Q_W-1:0] QOne = Q_W'(1) << (Q_W - 2);

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e r_state;
  state_e w_state_d;

  logic                     r_pend;
  logic                     w_pend_d;
  logic signed [ACC_W-1:0]  r_buf_ax, r_buf_ay, r_buf_az;
  logic signed [GYRO_W-1:0] r_buf_wx, r_buf_wy, r_buf_wz;
  logic signed [ACC_W-1:0]  r_op_ax, r_op_ay, r_op_az;
  logic signed [GYRO_W-1:0] r_op_wx, r_op_wy, r_op_wz;
  logic        [Q_W-1:0]    r_qw, r_qx, r_qy, r_qz;
  logic                     r_q_update;
  logic                     r_valid_in, w_valid_in_d;
  logic                     r_ready_out, w_ready_out_d;
  logic        [CNT_W-1:0]  r_upd_cnt, w_upd_cnt_d;
  logic        [CNT_W-1:0]  r_ovr_cnt, w_ovr_cnt_d;

  logic w_consume;
  logic w_hs_in;
  logic w_capture;
  logic w_overrun;
  logic w_to_fire;

  assign w_consume = (r_state == StIdle) && enable && r_pend;
  assign w_hs_in   = (r_state == StIssue) && r_valid_in && f_ready_in;
  assign w_capture = (r_state == StWait) && f_valid_out && r_ready_out;
  assign w_overrun = smp_valid && r_pend && !w_consume;

`ifdef MADGWICK_SEQ_TIMEOUT_EN
  localparam int unsigned ToW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [ToW-1:0] r_to_cnt, w_to_cnt_d;
  logic           r_to_err, w_to_err_d;

  // A real handshake in the same cycle as the limit is honoured over the watchdog.
  assign w_to_fire = (r_state != StIdle) && !w_hs_in && !w_capture &&
                     (r_to_cnt == ToW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    w_to_cnt_d = r_to_cnt;
    if (w_state_d != r_state) begin
      w_to_cnt_d = '0;
    end else if (r_state != StIdle) begin
      w_to_cnt_d = r_to_cnt + ToW'(1);
    end
    w_to_err_d = r_to_err;
    if (cnt_clr) begin
      w_to_err_d = 1'b0;
    end else if (w_to_fire) begin
      w_to_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_to_cnt <= '0;
      r_to_err <= 1'b0;
    end else begin
      r_to_cnt <= w_to_cnt_d;
      r_to_err <= w_to_err_d;
    end
  end

  assign timeout_err = r_to_err;
`else
  logic w_unused_to;
  assign w_unused_to = (TIMEOUT_CYCLES == 0);
  assign w_to_fire   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (w_consume) w_state_d = StIssue;
      StIssue: if (w_hs_in)   w_state_d = StWait;
      StWait:  if (w_capture) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
    if (w_to_fire) begin
      w_state_d = StIdle;
    end
  end

  // Next values of the registered handshake outputs, decoded from the next state.
  always_comb begin
    w_valid_in_d  = (w_state_d == StIssue);
    w_ready_out_d = (w_state_d == StWait);
`ifdef MADGWICK_SEQ_TIMEOUT_EN
    if (w_state_d == StIdle) begin
      w_ready_out_d = 1'b1;
    end
`endif
  end

  always_comb begin
    w_pend_d = r_pend;
    if (smp_valid) begin
      w_pend_d = 1'b1;
    end else if (w_consume) begin
      w_pend_d = 1'b0;
    end

    w_upd_cnt_d = r_upd_cnt;
    if (cnt_clr) begin
      w_upd_cnt_d = '0;
    end else if (w_capture) begin
      w_upd_cnt_d = r_upd_cnt + CNT_W'(1);
    end

    w_ovr_cnt_d = r_ovr_cnt;
    if (cnt_clr) begin
      w_ovr_cnt_d = '0;
    end else if (w_overrun && (r_ovr_cnt != '1)) begin
      w_ovr_cnt_d = r_ovr_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend      <= 1'b0;
      r_buf_ax    <= '0;
      r_buf_ay    <= '0;
      r_buf_az    <= '0;
      r_buf_wx    <= '0;
      r_buf_wy    <= '0;
      r_buf_wz    <= '0;
      r_op_ax     <= '0;
      r_op_ay     <= '0;
      r_op_az     <= '0;
      r_op_wx     <= '0;
      r_op_wy     <= '0;
      r_op_wz     <= '0;
      r_qw        <= QOne;
      r_qx        <= '0;
      r_qy        <= '0;
      r_qz        <= '0;
      r_q_update  <= 1'b0;
      r_valid_in  <= 1'b0;
      r_ready_out <= 1'b0;
      r_upd_cnt   <= '0;
      r_ovr_cnt   <= '0;
    end else begin
      r_pend      <= w_pend_d;
      r_q_update  <= w_capture;
      r_valid_in  <= w_valid_in_d;
      r_ready_out <= w_ready_out_d;
      r_upd_cnt   <= w_upd_cnt_d;
      r_ovr_cnt   <= w_ovr_cnt_d;
      if (smp_valid) begin
        r_buf_ax <= smp_a_x;
        r_buf_ay <= smp_a_y;
        r_buf_az <= smp_a_z;
        r_buf_wx <= smp_w_x;
        r_buf_wy <= smp_w_y;
        r_buf_wz <= smp_w_z;
      end
      // Operands come from the old buffer contents, so a coincident sample is not lost.
      if (w_consume) begin
        r_op_ax <= r_buf_ax;
        r_op_ay <= r_buf_ay;
        r_op_az <= r_buf_az;
        r_op_wx <= r_buf_wx;
        r_op_wy <= r_buf_wy;
        r_op_wz <= r_buf_wz;
      end
      if (w_capture) begin
        r_qw <= f_q_w;
        r_qx <= f_q_x;
        r_qy <= f_q_y;
        r_qz <= f_q_z;
      end
    end
  end

  assign f_valid_in  = r_valid_in;
  assign f_ready_out = r_ready_out;
  assign f_a_x       = r_op_ax;
  assign f_a_y       = r_op_ay;
  assign f_a_z       = r_op_az;
  assign f_w_x       = r_op_wx;
  assign f_w_y       = r_op_wy;
  assign f_w_z       = r_op_wz;
  assign q_w         = r_qw;
  assign q_x         = r_qx;
  assign q_y         = r_qy;
  assign q_z         = r_qz;
  assign q_update    = r_q_update;
  assign busy        = (r_state != StIdle);
  assign update_cnt  = r_upd_cnt;
  assign overrun_cnt = r_ovr_cnt;

endmodule
